// File: rtl/masked_operand_sharer_if.sv
// Handshake and share bus between an operand producer, the sharer and the downstream masked adder.
interface masked_operand_sharer_if #(
    parameter int WIDTH   = 64,
    parameter int NSHARES = 3
);
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH-1:0]           in_a;
    logic [WIDTH-1:0]           in_b;
    logic                       in_cin;
    logic                       seed_load;
    logic [WIDTH-1:0]           seed_a;
    logic [WIDTH-1:0]           seed_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [NSHARES*WIDTH-1:0]   a_shares;
    logic [NSHARES*WIDTH-1:0]   b_shares;
    logic [NSHARES-1:0]         cin_shares;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, seed_load, seed_a, seed_b, out_ready,
        output in_ready, out_valid, a_shares, b_shares, cin_shares
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, seed_load, seed_a, seed_b, out_ready,
        input  in_ready, out_valid, a_shares, b_shares, cin_shares
    );
endinterface

// File: rtl/masked_operand_sharer.sv
// Splits plain operands a, b and carry-in into NSHARES Boolean shares: NSHARES-1 random
// shares drawn from two Galois LFSRs, the last share being the running XOR residue.
module masked_operand_sharer #(
    parameter int          WIDTH   = 64,
    parameter int          NSHARES = 3,
    parameter logic [63:0] SEED_A  = 64'h0123_4567_89AB_CDEF,
    parameter logic [63:0] SEED_B  = 64'hFEDC_BA98_7654_3211,
    parameter logic [63:0] POLY    = 64'hD800_0000_0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    masked_operand_sharer_if.slave  bus
);
    localparam int KW = (NSHARES > 2) ? $clog2(NSHARES - 1) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(NSHARES - 2);
    localparam logic [WIDTH-1:0] SEED_A_W = SEED_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_B_W = SEED_B[WIDTH-1:0];
    localparam logic [WIDTH-1:0] POLY_W   = POLY[WIDTH-1:0];

    typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  lfsr_a_reg, lfsr_b_reg;
    logic [WIDTH-1:0]  acc_a_reg, acc_b_reg;
    logic              acc_c_reg;
    logic [KW-1:0]     k_reg;

    logic [WIDTH-1:0]  acc_a_next, acc_b_next;
    logic              acc_c_next;
    logic              cin_rnd;
    logic              last_share;

    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY_W : '0);
    endfunction

    assign cin_rnd    = lfsr_a_reg[0] ^ lfsr_b_reg[WIDTH-1];
    assign acc_a_next = acc_a_reg ^ lfsr_a_reg;
    assign acc_b_next = acc_b_reg ^ lfsr_b_reg;
    assign acc_c_next = acc_c_reg ^ cin_rnd;
    assign last_share = (state_reg == GEN) && (k_reg == K_LAST);

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)  state_next = GEN;
            GEN:     if (last_share)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Seeds are loaded before the operand capture on the same edge, so an operand
    // accepted together with seed_load is masked with the fresh seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a_reg <= SEED_A_W;
            lfsr_b_reg <= SEED_B_W;
            acc_a_reg  <= '0;
            acc_b_reg  <= '0;
            acc_c_reg  <= 1'b0;
            k_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.seed_load) begin
                        lfsr_a_reg <= (bus.seed_a == '0) ? SEED_A_W : bus.seed_a;
                        lfsr_b_reg <= (bus.seed_b == '0) ? SEED_B_W : bus.seed_b;
                    end
                    if (bus.in_valid) begin
                        acc_a_reg <= bus.in_a;
                        acc_b_reg <= bus.in_b;
                        acc_c_reg <= bus.in_cin;
                        k_reg     <= '0;
                    end
                end
                GEN: begin
                    acc_a_reg  <= acc_a_next;
                    acc_b_reg  <= acc_b_next;
                    acc_c_reg  <= acc_c_next;
                    lfsr_a_reg <= galois_step(lfsr_a_reg);
                    lfsr_b_reg <= galois_step(lfsr_b_reg);
                    k_reg      <= k_reg + KW'(1);
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSHARES; gi++) begin : g_share
            logic [WIDTH-1:0] a_share_reg, b_share_reg;
            logic             c_share_reg;
            logic             share_we;
            logic [WIDTH-1:0] a_share_d, b_share_d;
            logic             c_share_d;

            if (gi < NSHARES - 1) begin : g_rnd
                assign share_we  = (state_reg == GEN) && (k_reg == KW'(gi));
                assign a_share_d = lfsr_a_reg;
                assign b_share_d = lfsr_b_reg;
                assign c_share_d = cin_rnd;
            end else begin : g_residue
                // Final share is the accumulator after absorbing the last random share.
                assign share_we  = last_share;
                assign a_share_d = acc_a_next;
                assign b_share_d = acc_b_next;
                assign c_share_d = acc_c_next;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_share_reg <= '0;
                    b_share_reg <= '0;
                    c_share_reg <= 1'b0;
                end else if (share_we) begin
                    a_share_reg <= a_share_d;
                    b_share_reg <= b_share_d;
                    c_share_reg <= c_share_d;
                end
            end

            assign bus.a_shares[gi*WIDTH +: WIDTH] = a_share_reg;
            assign bus.b_shares[gi*WIDTH +: WIDTH] = b_share_reg;
            assign bus.cin_shares[gi]              = c_share_reg;
        end
    endgenerate
endmodule
